// File: rtl/pwr_seq_pkg.sv
// Shared types and constants for the power-rail sequencer: FSM states, register map,
// CTRL command bits and register reset values.
package pwr_seq_pkg;

  typedef enum logic [2:0] {
    StOff      = 3'd0,
    StRampUp   = 3'd1,
    StWaitPg   = 3'd2,
    StOn       = 3'd3,
    StRampDown = 3'd4,
    StFault    = 3'd5
  } pwr_state_e;

  localparam logic [1:0] AddrCtrl      = 2'd0;
  localparam logic [1:0] AddrStepDelay = 2'd1;
  localparam logic [1:0] AddrPgTimeout = 2'd2;
  localparam logic [1:0] AddrStatus    = 2'd3;

  localparam int unsigned CtrlUpBit       = 0;
  localparam int unsigned CtrlDownBit     = 1;
  localparam int unsigned CtrlClrFaultBit = 2;

  localparam logic [15:0] StepDelayRst = 16'd1000;
  localparam logic [15:0] PgTimeoutRst = 16'd50000;

  // A programmed zero still has to advance the sequence.
  function automatic logic [15:0] clamp_min1(input logic [15:0] v);
    return (v == 16'd0) ? 16'd1 : v;
  endfunction

endpackage

// File: rtl/pwr_seq_sync.sv
// Two-flop synchronizer for the asynchronous board power-good input.
module pwr_seq_sync (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pwr_seq_ctrl.sv
// Avalon-MM controlled power-rail sequencer: ramps rail enables up and down with a programmable
// step delay, waits for power-good with a timeout, and latches faults until cleared.
module pwr_seq_ctrl
  import pwr_seq_pkg::*;
#(
  parameter int NUM_RAILS = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           address,
  input  logic                 chipselect,
  input  logic                 write_n,
  input  logic [31:0]          writedata,
  output logic [31:0]          readdata,
  input  logic                 pwr_good,
  output logic [NUM_RAILS-1:0] pwr_en,
  output logic                 irq
);

  pwr_state_e           r_state, w_state_d, w_up_state, w_down_state;
  logic [NUM_RAILS-1:0] r_en, w_en_d, w_en_up, w_en_dn;
  logic [15:0]          r_cnt, w_cnt_d, w_up_cnt;
  logic [15:0]          r_step_delay, r_pg_timeout, w_load_step, w_load_tmo;
  logic                 w_wr, w_ctrl_wr, w_up, w_down, w_clr, w_pg_s, w_cnt_last;
  logic                 w_fault, w_on, w_busy;
  logic                 w_unused;

  pwr_seq_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (pwr_good),
    .o_q   (w_pg_s)
  );

  assign w_wr      = chipselect & ~write_n;
  assign w_ctrl_wr = w_wr && (address == AddrCtrl);
  // DOWN wins over UP when both arrive in one write.
  assign w_up      = w_ctrl_wr & writedata[CtrlUpBit] & ~writedata[CtrlDownBit];
  assign w_down    = w_ctrl_wr & writedata[CtrlDownBit];
  assign w_clr     = w_ctrl_wr & writedata[CtrlClrFaultBit];
  assign w_unused  = ^writedata[31:16];

  assign w_load_step = clamp_min1(r_step_delay);
  assign w_load_tmo  = clamp_min1(r_pg_timeout);
  assign w_cnt_last  = (r_cnt <= 16'd1);

  // Rails form a thermometer code, so ramping is a shift in either direction.
  assign w_en_up      = (r_en << 1) | NUM_RAILS'(1);
  assign w_en_dn      = r_en >> 1;
  assign w_up_state   = w_en_up[NUM_RAILS-1] ? StWaitPg : StRampUp;
  assign w_up_cnt     = w_en_up[NUM_RAILS-1] ? w_load_tmo : w_load_step;
  assign w_down_state = (w_en_dn == '0) ? StOff : StRampDown;

  always_comb begin
    w_state_d = r_state;
    w_en_d    = r_en;
    w_cnt_d   = r_cnt;
    case (r_state)
      StOff: begin
        if (w_up) begin
          w_state_d = w_up_state;
          w_en_d    = w_en_up;
          w_cnt_d   = w_up_cnt;
        end
      end
      StRampUp: begin
        if (w_down) begin
          w_state_d = w_down_state;
          w_en_d    = w_en_dn;
          w_cnt_d   = w_load_step;
        end else if (w_cnt_last) begin
          w_state_d = w_up_state;
          w_en_d    = w_en_up;
          w_cnt_d   = w_up_cnt;
        end else begin
          w_cnt_d = r_cnt - 16'd1;
        end
      end
      StWaitPg: begin
        if (!w_pg_s && w_cnt_last) begin
          w_state_d = StFault;
          w_en_d    = '0;
          w_cnt_d   = '0;
        end else if (w_down) begin
          w_state_d = w_down_state;
          w_en_d    = w_en_dn;
          w_cnt_d   = w_load_step;
        end else if (w_pg_s) begin
          w_state_d = StOn;
        end else begin
          w_cnt_d = r_cnt - 16'd1;
        end
      end
      StOn: begin
        if (!w_pg_s) begin
          w_state_d = StFault;
          w_en_d    = '0;
          w_cnt_d   = '0;
        end else if (w_down) begin
          w_state_d = w_down_state;
          w_en_d    = w_en_dn;
          w_cnt_d   = w_load_step;
        end
      end
      StRampDown: begin
        if (w_cnt_last) begin
          w_state_d = w_down_state;
          w_en_d    = w_en_dn;
          w_cnt_d   = w_load_step;
        end else begin
          w_cnt_d = r_cnt - 16'd1;
        end
      end
      StFault: begin
        if (w_clr) w_state_d = StOff;
      end
      default: begin
        w_state_d = StOff;
        w_en_d    = '0;
        w_cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= StOff;
      r_en         <= '0;
      r_cnt        <= '0;
      r_step_delay <= StepDelayRst;
      r_pg_timeout <= PgTimeoutRst;
    end else begin
      r_state <= w_state_d;
      r_en    <= w_en_d;
      r_cnt   <= w_cnt_d;
      if (w_wr && address == AddrStepDelay) r_step_delay <= writedata[15:0];
      if (w_wr && address == AddrPgTimeout) r_pg_timeout <= writedata[15:0];
    end
  end

  assign w_fault = (r_state == StFault);
  assign w_on    = (r_state == StOn);
  assign w_busy  = (r_state == StRampUp) || (r_state == StWaitPg) || (r_state == StRampDown);

  always_comb begin
    readdata = '0;
    case (address)
      AddrCtrl:      readdata = 32'(r_en);
      AddrStepDelay: readdata = {16'b0, r_step_delay};
      AddrPgTimeout: readdata = {16'b0, r_pg_timeout};
      AddrStatus:    readdata = {26'b0, w_fault, w_on, w_busy, r_state};
      default:       readdata = '0;
    endcase
  end

  assign pwr_en = r_en;
  assign irq    = w_fault;

endmodule

// File: tb/tb_pwr_seq_ctrl.sv
// Self-checking bench for pwr_seq_ctrl: register-access vector table, directed sequencing
// scenarios, and randomized traffic against a cycle-time reference model.
module tb_pwr_seq_ctrl;

  localparam int N = 3;
  localparam int MOff = 0, MUp = 1, MWait = 2, MOn = 3, MDown = 4, MFault = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic          pwr_good;
  logic [N-1:0]  pwr_en;
  logic          irq;

  int n_tests = 0;
  int n_fail  = 0;

  pwr_seq_ctrl #(.NUM_RAILS(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .pwr_good   (pwr_good),
    .pwr_en     (pwr_en),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic        cs;
    logic        wn;
    logic [1:0]  rd_addr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
    address    = a;
    chipselect = 1'b0;
    #1;
    check(name, readdata, exp);
  endtask

  // Reference model: rails on as a count, transitions scheduled at absolute cycle numbers.
  int m_mode, m_rails, m_t, m_next, m_dead, m_step, m_tmo;
  bit m_pg_line[$];

  function automatic int max1(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic model_reset();
    m_mode = MOff; m_rails = 0; m_t = 0; m_next = 0; m_dead = 0;
    m_step = 1000; m_tmo = 50000;
    m_pg_line = '{1'b0, 1'b0};
  endtask

  task automatic model_down(input int d);
    m_rails--;
    if (m_rails == 0) m_mode = MOff;
    else begin
      m_mode = MDown;
      m_next = m_t + d;
    end
  endtask

  task automatic model_rail_up(input int d, input int tmo);
    m_rails++;
    if (m_rails == N) begin
      m_mode = MWait;
      m_dead = m_t + tmo;
    end else begin
      m_mode = MUp;
      m_next = m_t + d;
    end
  endtask

  task automatic model_step(input bit cs, input bit wn, input logic [1:0] a,
                            input logic [31:0] wd, input bit pg_in);
    bit wrx, up, dn, clr, pg;
    int d, tmo;
    wrx = cs && !wn;
    up  = wrx && a == 2'd0 && wd[0];
    dn  = wrx && a == 2'd0 && wd[1];
    clr = wrx && a == 2'd0 && wd[2];
    pg  = m_pg_line[0];
    d   = max1(m_step);
    tmo = max1(m_tmo);
    m_t++;
    case (m_mode)
      MOff:   if (up && !dn) model_rail_up(d, tmo);
      MUp: begin
        if (dn) model_down(d);
        else if (m_t == m_next) model_rail_up(d, tmo);
      end
      MWait: begin
        if (!pg && m_t == m_dead) begin m_mode = MFault; m_rails = 0; end
        else if (dn) model_down(d);
        else if (pg) m_mode = MOn;
      end
      MOn: begin
        if (!pg) begin m_mode = MFault; m_rails = 0; end
        else if (dn) model_down(d);
      end
      MDown:  if (m_t == m_next) model_down(d);
      MFault: if (clr) m_mode = MOff;
      default: m_mode = MOff;
    endcase
    if (wrx && a == 2'd1) m_step = int'(wd[15:0]);
    if (wrx && a == 2'd2) m_tmo  = int'(wd[15:0]);
    void'(m_pg_line.pop_front());
    m_pg_line.push_back(pg_in);
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] a);
    logic [31:0] s;
    case (a)
      2'd0: return 32'((1 << m_rails) - 1);
      2'd1: return 32'(m_step);
      2'd2: return 32'(m_tmo);
      default: begin
        s = 32'(m_mode);
        s[3] = (m_mode == MUp) || (m_mode == MWait) || (m_mode == MDown);
        s[4] = (m_mode == MOn);
        s[5] = (m_mode == MFault);
        return s;
      end
    endcase
  endfunction

  initial begin
    reset = 1'b1; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = 32'd0; pwr_good = 1'b0;

    vecs[0] = '{2'd1, 32'hFFFF_0007, 1'b1, 1'b0, 2'd1, 32'h7};
    vecs[1] = '{2'd2, 32'hABCD_1234, 1'b1, 1'b0, 2'd2, 32'h1234};
    vecs[2] = '{2'd1, 32'h0000_0099, 1'b0, 1'b0, 2'd1, 32'h7};
    vecs[3] = '{2'd2, 32'h0000_0055, 1'b1, 1'b1, 2'd2, 32'h1234};
    vecs[4] = '{2'd3, 32'hFFFF_FFFF, 1'b1, 1'b0, 2'd3, 32'h0};
    vecs[5] = '{2'd0, 32'h0000_0004, 1'b1, 1'b0, 2'd3, 32'h0};
    vecs[6] = '{2'd0, 32'h0000_0003, 1'b1, 1'b0, 2'd0, 32'h0};
    vecs[7] = '{2'd0, 32'h0000_0002, 1'b1, 1'b0, 2'd3, 32'h0};
    vecs[8] = '{2'd0, 32'h0000_0001, 1'b0, 1'b0, 2'd0, 32'h0};
    vecs[9] = '{2'd1, 32'h0000_0000, 1'b1, 1'b0, 2'd1, 32'h0};

    // Reset state
    tick(3);
    check("rst_en", 32'(pwr_en), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    rd_chk("rst_step", 2'd1, 32'd1000);
    rd_chk("rst_tmo", 2'd2, 32'd50000);
    rd_chk("rst_status", 2'd3, 32'h0);
    reset = 1'b0;
    tick(1);

    for (int i = 0; i < 10; i++) begin
      address = vecs[i].addr; writedata = vecs[i].wdata;
      chipselect = vecs[i].cs; write_n = vecs[i].wn;
      @(posedge clk);
      #1;
      chipselect = 1'b0; write_n = 1'b1;
      rd_chk($sformatf("vec%0d", i), vecs[i].rd_addr, vecs[i].exp);
    end

    // STEP_DELAY=0 behaves as a one-cycle step
    pwr_good = 1'b1;
    tick(3);
    wr(2'd0, 32'h1);  check("d0_en1", 32'(pwr_en), 32'h1);
    tick(1);          check("d0_en3", 32'(pwr_en), 32'h3);
    tick(1);          check("d0_en7", 32'(pwr_en), 32'h7);
    tick(1);          rd_chk("d0_on", 2'd3, 32'h13);
    wr(2'd0, 32'h2);  check("d0_dn3", 32'(pwr_en), 32'h3);
    tick(1);          check("d0_dn1", 32'(pwr_en), 32'h1);
    tick(1);          check("d0_dn0", 32'(pwr_en), 32'h0);
    rd_chk("d0_off", 2'd3, 32'h0);

    // Ramp up with STEP_DELAY=4, power good present
    wr(2'd1, 32'd4);
    wr(2'd0, 32'h1);  check("s1_en1", 32'(pwr_en), 32'h1);
    tick(3);          check("s1_en1_hold", 32'(pwr_en), 32'h1);
    tick(1);          check("s1_en3", 32'(pwr_en), 32'h3);
    tick(4);          check("s1_en7", 32'(pwr_en), 32'h7);
    rd_chk("s1_waitpg", 2'd3, 32'h0A);
    tick(1);          rd_chk("s1_on", 2'd3, 32'h13);
    check("s1_irq", 32'(irq), 32'h0);
    wr(2'd0, 32'h2);
    tick(10);         rd_chk("s1_off", 2'd3, 32'h0);

    // Power-good timeout
    pwr_good = 1'b0;
    wr(2'd2, 32'd10);
    tick(2);
    wr(2'd0, 32'h1);
    tick(8);          check("s2_en7", 32'(pwr_en), 32'h7);
    tick(9);          rd_chk("s2_still_wait", 2'd3, 32'h0A);
    tick(1);          check("s2_en0", 32'(pwr_en), 32'h0);
    check("s2_irq", 32'(irq), 32'h1);
    rd_chk("s2_fault", 2'd3, 32'h25);
    wr(2'd0, 32'h1);  rd_chk("s2_up_ign", 2'd3, 32'h25);
    check("s2_up_ign_en", 32'(pwr_en), 32'h0);
    wr(2'd0, 32'h4);  rd_chk("s2_clr", 2'd3, 32'h0);
    check("s2_clr_irq", 32'(irq), 32'h0);

    // DOWN from ON with STEP_DELAY=3
    pwr_good = 1'b1;
    wr(2'd1, 32'd3);
    tick(3);
    wr(2'd0, 32'h1);
    tick(7);          rd_chk("s3_on", 2'd3, 32'h13);
    wr(2'd0, 32'h2);  check("s3_en3", 32'(pwr_en), 32'h3);
    rd_chk("s3_rampdn", 2'd3, 32'h0C);
    tick(2);          check("s3_en3_hold", 32'(pwr_en), 32'h3);
    tick(1);          check("s3_en1", 32'(pwr_en), 32'h1);
    tick(2);          check("s3_en1_hold", 32'(pwr_en), 32'h1);
    tick(1);          check("s3_en0", 32'(pwr_en), 32'h0);
    rd_chk("s3_off", 2'd3, 32'h0);

    // DOWN during RAMP_UP at 011
    wr(2'd0, 32'h1);
    tick(3);          check("s4_en3", 32'(pwr_en), 32'h3);
    wr(2'd0, 32'h2);  check("s4_en1", 32'(pwr_en), 32'h1);
    tick(2);          check("s4_en1_hold", 32'(pwr_en), 32'h1);
    tick(1);          check("s4_en0", 32'(pwr_en), 32'h0);
    rd_chk("s4_off", 2'd3, 32'h0);
    for (int k = 0; k < 6; k++) begin
      tick(1);
      check("s4_no_rail2", 32'(pwr_en[2]), 32'h0);
    end

    // UP+DOWN in one write
    wr(2'd0, 32'h3);  check("s5_off_en", 32'(pwr_en), 32'h0);
    rd_chk("s5_off_status", 2'd3, 32'h0);
    wr(2'd0, 32'h1);
    tick(7);          rd_chk("s5_on", 2'd3, 32'h13);
    wr(2'd0, 32'h3);  check("s5_dn_en", 32'(pwr_en), 32'h3);
    rd_chk("s5_rampdn", 2'd3, 32'h0C);
    tick(6);          check("s5_off", 32'(pwr_en), 32'h0);

    // Asynchronous reset mid-ramp
    wr(2'd2, 32'd7);
    wr(2'd0, 32'h1);
    tick(3);          check("s6_en3", 32'(pwr_en), 32'h3);
    #2;
    reset = 1'b1;
    #1;
    check("s6_async_en", 32'(pwr_en), 32'h0);
    check("s6_async_irq", 32'(irq), 32'h0);
    rd_chk("s6_step", 2'd1, 32'd1000);
    rd_chk("s6_tmo", 2'd2, 32'd50000);
    rd_chk("s6_status", 2'd3, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("s6_after_en", 32'(pwr_en), 32'h0);

    // Randomized traffic against the reference model
    model_reset();
    begin
      bit pg_r;
      pg_r = 1'b1;
      for (int i = 0; i < 4000; i++) begin
        logic [1:0]  a;
        logic [31:0] d;
        bit          cs, wn;
        int          r;
        cs = 1'b0; wn = 1'b1;
        a = 2'($urandom_range(0, 3));
        d = $urandom;
        if (i == 0) begin
          cs = 1'b1; wn = 1'b0; a = 2'd1; d = 32'h2;
        end else if (i == 1) begin
          cs = 1'b1; wn = 1'b0; a = 2'd2; d = 32'h8;
        end else if ($urandom_range(0, 5) == 0) begin
          cs = 1'b1;
          wn = ($urandom_range(0, 4) == 0);
          r = $urandom_range(0, 19);
          case (a)
            2'd0: d[2:0] = (r < 10) ? 3'b001 : (r < 15) ? 3'b010 : (r < 18) ? 3'b100 : 3'(r);
            2'd1: d[15:0] = 16'($urandom_range(0, 5));
            2'd2: d[15:0] = 16'($urandom_range(0, 15));
            default: ;
          endcase
        end
        if (pg_r ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 4) == 0)) pg_r = ~pg_r;
        address = a; writedata = d; chipselect = cs; write_n = wn; pwr_good = pg_r;
        model_step(cs, wn, a, d, pg_r);
        @(posedge clk);
        #1;
        chipselect = 1'b0; write_n = 1'b1;
        address = 2'($urandom_range(0, 3));
        #1;
        check("rnd_en", 32'(pwr_en), model_read(2'd0));
        check("rnd_irq", 32'(irq), 32'(m_mode == MFault));
        check($sformatf("rnd_rd%0d", address), readdata, model_read(address));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
